audio_stream_sched: RTL and testbench
=====================================

Name: audio_stream_sched

Overview:
- Sequences the audio_codec read/write handshakes around an external processing stage (filter, echo, etc.) that has variable latency and valid/ready flow control.
- Reads each stereo sample from the codec ADC FIFO into a single-entry holding register and offers it to the processing stage.
- Buffers processed samples in an internal FIFO and feeds them to the codec DAC FIFO, starting only after a prefill threshold is reached.
- Writes silence on underrun, drops samples on overrun, and counts both events. Sits between audio_codec and the processing datapath in the top level.

Parameters:
- DATA_W, 24, audio sample width per channel.
- DEPTH, 8, output FIFO entries (stereo pairs); power of 2, at least 2.
- PREFILL, 4, FIFO occupancy required before the first write; 1 to DEPTH.
- CNT_W, 16, width of the event counters.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; low returns the block to IDLE.
- read_ready  in  1  codec ADC FIFO has a sample.
- write_ready  in  1  codec DAC FIFO has space.
- readdata_left, readdata_right  in  DATA_W each  codec ADC data.
- read  out  1  codec read strobe.
- write  out  1  codec write strobe.
- writedata_left, writedata_right  out  DATA_W each  codec DAC data.
- proc_in_valid  out  1  holding register is occupied.
- proc_in_ready  in  1  processing stage accepts the held sample.
- proc_in_left, proc_in_right  out  DATA_W each  held sample.
- proc_out_valid  in  1  processed sample available.
- proc_out_ready  out  1  output FIFO not full.
- proc_out_left, proc_out_right  in  DATA_W each  processed sample.
- underrun_cnt  out  CNT_W  silence writes issued; saturating.
- overrun_cnt  out  CNT_W  input samples dropped; saturating.
- running  out  1  high while the state machine is in RUN.

Behaviour:
- States: IDLE, PREFILL, RUN.
  - IDLE -> PREFILL when enable=1.
  - PREFILL -> RUN when fifo_count >= PREFILL (evaluated on the registered count).
  - Any state -> IDLE on enable=0 at the next edge. This flushes the FIFO and clears the holding register. Counters are kept.
- Reset (reset=0, asynchronous):
  - State = IDLE; FIFO empty; holding register empty; both counters 0.
  - read=0, write=0, proc_in_valid=0, running=0.
  - writedata_left/right=0; proc_in_left/right=0.
  - proc_out_ready=1: the FIFO is empty, and the output is combinationally !full.
- read = read_ready & (state != IDLE). It is combinational; codec data is captured on the same edge.
  - Holding register empty, or being drained this cycle (proc_in_valid & proc_in_ready): load the sample; proc_in_valid=1 from the next cycle.
  - Holding register occupied and not draining: the sample is still read, to keep the codec FIFO from overflowing, and discarded. overrun_cnt += 1.
- Holding register clears on proc_in_valid & proc_in_ready unless it is reloaded on the same edge. proc_in_left/right hold stable while proc_in_valid=1 and proc_in_ready=0.
- FIFO push on proc_out_valid & proc_out_ready, in every state except IDLE. In IDLE, proc_out_ready=1 and the data is discarded.
- write = write_ready & (state == RUN). This is combinational; at most one write per cycle, and back-to-back writes are allowed.
  - FIFO non-empty: writedata = FIFO head (first-word-fall-through); pop on the same edge.
  - FIFO empty: writedata = 0; underrun_cnt += 1. State stays RUN; there is no return to PREFILL.
- Simultaneous push and pop: count is unchanged. A push is allowed when full only if a pop occurs on the same edge; proc_out_ready = !full | (write & non-empty).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- running = registered (state == RUN).

Test Plan:
- Reset mid-stream: hold RUN with FIFO at 3 entries, pulse reset low for 1 cycle -> all outputs at reset values asynchronously; FIFO count 0; state IDLE.
- Prefill: enable=1, write_ready=1, push samples 0x000001..0x000004 -> write stays 0 until 4 entries are held. running rises the cycle after the 4th push. Writes then emit 1,2,3,4 in order.
- Underrun: in RUN with FIFO empty and write_ready=1 for 3 cycles -> write=1 and writedata=0 each cycle; underrun_cnt=3.
- Overrun: proc_in_ready=0, read_ready=1 for 4 cycles -> read pulses 4 times; held sample equals the first captured value; overrun_cnt=3.
- Full FIFO: DEPTH=8, write_ready=0, push 9 samples -> proc_out_ready=0 after 8. Asserting write_ready for 1 cycle pops sample 1 and accepts sample 9 on that edge; count stays 8.
- Saturation: CNT_W=4, force 20 underruns -> underrun_cnt holds at 15.

Source files
------------

// File: rtl/audio_stream_sched.sv
// ---------------------------------------------------------------------------
// audio_stream_sched
//
// Schedules the codec read/write handshakes around an external processing
// stage that has variable latency and valid/ready flow control.
//   - The codec ADC sample is captured into a single-entry holding register.
//     The register is offered to the processing stage as proc_in_*.
//   - Processed samples are queued in a first-word-fall-through FIFO. The
//     FIFO feeds the codec DAC once PREFILL entries have accumulated.
//   - If the FIFO is empty when the DAC asks for data, silence is written
//     and counted as an underrun. If an ADC sample arrives while the holding
//     register is still occupied, the sample is read, dropped and counted
//     as an overrun.
//
// Ports
//   CLOCK_50, reset              clock, asynchronous active-low reset
//   enable                       run request; low flushes and returns to IDLE
//   read_ready / read            codec ADC side: sample present / read strobe
//   readdata_left/right          codec ADC data
//   write_ready / write          codec DAC side: space present / write strobe
//   writedata_left/right         codec DAC data (FIFO head, or 0 on underrun)
//   proc_in_valid/ready/left/right    holding register to the processing stage
//   proc_out_valid/ready/left/right   processing stage to the output FIFO
//   underrun_cnt, overrun_cnt    saturating event counters
//   running                      high while in RUN
// ---------------------------------------------------------------------------
module audio_stream_sched #(
    parameter int DATA_W  = 24,
    parameter int DEPTH   = 8,
    parameter int PREFILL = 4,
    parameter int CNT_W   = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              proc_in_valid,
    input  logic              proc_in_ready,
    output logic [DATA_W-1:0] proc_in_left,
    output logic [DATA_W-1:0] proc_in_right,
    input  logic              proc_out_valid,
    output logic              proc_out_ready,
    input  logic [DATA_W-1:0] proc_out_left,
    input  logic [DATA_W-1:0] proc_out_right,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic              running
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PREFILL_CNT = PREFILL[AW:0];
    localparam logic [AW:0] DEPTH_CNT   = DEPTH[AW:0];

    typedef enum logic [1:0] {ST_IDLE, ST_PREFILL, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]   hold_left_q, hold_left_d;
    logic [DATA_W-1:0]   hold_right_q, hold_right_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [CNT_W-1:0]    underrun_q, underrun_d;
    logic [CNT_W-1:0]    overrun_q, overrun_d;
    logic                running_q;
    logic [2*DATA_W-1:0] mem_q [DEPTH];

    logic                fifo_empty, fifo_full;
    logic                push, pop, drain;
    logic [2*DATA_W-1:0] head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign head       = mem_q[rd_ptr_q];

    assign read  = read_ready & (state_q != ST_IDLE);
    assign write = write_ready & (state_q == ST_RUN);
    assign pop   = write & ~fifo_empty;
    assign drain = hold_valid_q & proc_in_ready;

    // A full FIFO can still accept when the head leaves on the same edge.
    // In IDLE the FIFO is held empty, so the sample is accepted and dropped.
    assign proc_out_ready = ~fifo_full | pop;
    assign push = proc_out_valid & proc_out_ready & (state_q != ST_IDLE);

    assign writedata_left  = pop ? head[2*DATA_W-1:DATA_W] : '0;
    assign writedata_right = pop ? head[DATA_W-1:0]        : '0;
    assign proc_in_valid   = hold_valid_q;
    assign proc_in_left    = hold_left_q;
    assign proc_in_right   = hold_right_q;
    assign underrun_cnt    = underrun_q;
    assign overrun_cnt     = overrun_q;
    assign running         = running_q;

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        underrun_d   = underrun_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE:    state_d = ST_PREFILL;
            ST_PREFILL: if (count_q >= PREFILL_CNT) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase

        // Holding register: a drain frees the slot for a load on the same edge.
        if (drain) hold_valid_d = 1'b0;
        if (read) begin
            if (!hold_valid_q || drain) begin
                hold_valid_d = 1'b1;
                hold_left_d  = readdata_left;
                hold_right_d = readdata_right;
            end else if (overrun_q != '1) begin
                overrun_d = overrun_q + 1'b1;
            end
        end

        if (write && fifo_empty && underrun_q != '1) underrun_d = underrun_q + 1'b1;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        // Dropping enable flushes the datapath; event counters are kept.
        if (!enable) begin
            state_d      = ST_IDLE;
            hold_valid_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            underrun_q   <= '0;
            overrun_q    <= '0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
            running_q    <= (state_d == ST_RUN);
        end
    end

    // Storage carries no reset: contents are only visible through count_q.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= {proc_out_left, proc_out_right};
    end

endmodule

// File: tb/tb_audio_stream_sched.sv
module tb_audio_stream_sched;

    localparam int DATA_W = 24;
    localparam int CNT_W  = 4;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              enable;
    logic              read_ready;
    logic              write_ready;
    logic [DATA_W-1:0] readdata_left, readdata_right;
    logic              read, write;
    logic [DATA_W-1:0] writedata_left, writedata_right;
    logic              proc_in_valid, proc_in_ready;
    logic [DATA_W-1:0] proc_in_left, proc_in_right;
    logic              proc_out_valid, proc_out_ready;
    logic [DATA_W-1:0] proc_out_left, proc_out_right;
    logic [CNT_W-1:0]  underrun_cnt, overrun_cnt;
    logic              running;

    int n_checks = 0;
    int n_fail   = 0;

    audio_stream_sched #(
        .DATA_W (DATA_W),
        .DEPTH  (8),
        .PREFILL(4),
        .CNT_W  (CNT_W)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .enable         (enable),
        .read_ready     (read_ready),
        .write_ready    (write_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .read           (read),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .proc_in_valid  (proc_in_valid),
        .proc_in_ready  (proc_in_ready),
        .proc_in_left   (proc_in_left),
        .proc_in_right  (proc_in_right),
        .proc_out_valid (proc_out_valid),
        .proc_out_ready (proc_out_ready),
        .proc_out_left  (proc_out_left),
        .proc_out_right (proc_out_right),
        .underrun_cnt   (underrun_cnt),
        .overrun_cnt    (overrun_cnt),
        .running        (running)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[%0t] FAIL %s: got %0h, expected %0h", $time, tag, obs, exp);
        end else begin
            $display("[%0t] ok   %s: %0h", $time, tag, obs);
        end
    endtask

    // Advance one cycle; returns on the falling edge where inputs are driven.
    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
        readdata_left = '0; readdata_right = '0; proc_in_ready = 1'b0;
        proc_out_valid = 1'b0; proc_out_left = '0; proc_out_right = '0;

        // Reset state
        @(negedge CLOCK_50); #1;
        check_val("rst_read", read, 0);
        check_val("rst_write", write, 0);
        check_val("rst_pin_valid", proc_in_valid, 0);
        check_val("rst_running", running, 0);
        check_val("rst_wdata", {writedata_left, writedata_right}, 0);
        check_val("rst_pin_data", {proc_in_left, proc_in_right}, 0);
        check_val("rst_pout_ready", proc_out_ready, 1);
        check_val("rst_cnts", {underrun_cnt, overrun_cnt}, 0);
        reset = 1'b1;

        // Prefill: nothing written until four entries are held
        enable = 1'b1; write_ready = 1'b1;
        tick();
        #1 check_val("pf_running0", running, 0);
        for (int i = 1; i <= 4; i++) begin
            proc_out_valid = 1'b1;
            proc_out_left  = DATA_W'(i);
            proc_out_right = DATA_W'(24'h800000 | i);
            #1 check_val("pf_write_hold", write, 0);
            tick();
        end
        proc_out_valid = 1'b0;
        #1 check_val("pf_write_at4", write, 0);
        check_val("pf_running_at4", running, 0);
        tick();
        #1 check_val("pf_running1", running, 1);
        for (int i = 1; i <= 4; i++) begin
            check_val("pf_write", write, 1);
            check_val("pf_wdata", {writedata_left, writedata_right},
                      {DATA_W'(i), DATA_W'(24'h800000 | i)});
            tick(); #1;
        end

        // Underrun: three silence writes
        for (int k = 0; k < 3; k++) begin
            check_val("ur_write", write, 1);
            check_val("ur_wdata", {writedata_left, writedata_right}, 0);
            tick(); #1;
        end
        write_ready = 1'b0;
        #1 check_val("ur_cnt3", underrun_cnt, 3);

        // Overrun: four reads into a stalled holding register
        read_ready = 1'b1; proc_in_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            readdata_left  = DATA_W'(24'h100 + k);
            readdata_right = DATA_W'(24'h200 + k);
            #1 check_val("or_read", read, 1);
            tick();
        end
        read_ready = 1'b0;
        #1 check_val("or_valid", proc_in_valid, 1);
        check_val("or_held", {proc_in_left, proc_in_right}, {24'h000100, 24'h000200});
        check_val("or_cnt3", overrun_cnt, 3);
        // Load on the same edge as a drain is not an overrun
        proc_in_ready = 1'b1; read_ready = 1'b1;
        readdata_left = 24'h000155; readdata_right = 24'h000255;
        tick();
        read_ready = 1'b0;
        #1 check_val("or_reload", {proc_in_valid, proc_in_left, proc_in_right},
                     {1'b1, 24'h000155, 24'h000255});
        check_val("or_cnt_keep", overrun_cnt, 3);
        tick();
        #1 check_val("or_drained", proc_in_valid, 0);
        proc_in_ready = 1'b0;

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 8; i++) begin
            proc_out_valid = 1'b1;
            proc_out_left  = DATA_W'(24'h10 + i);
            proc_out_right = DATA_W'(24'h20 + i);
            #1 check_val("full_ready", proc_out_ready, 1);
            tick();
        end
        proc_out_left = 24'h19; proc_out_right = 24'h29;
        #1 check_val("full_blocked", proc_out_ready, 0);
        tick();
        write_ready = 1'b1;
        #1 check_val("full_pp_write", write, 1);
        check_val("full_pp_wdata", {writedata_left, writedata_right}, {24'h11, 24'h21});
        check_val("full_pp_ready", proc_out_ready, 1);
        tick();
        write_ready = 1'b0; proc_out_valid = 1'b0;
        #1 check_val("full_still8", proc_out_ready, 0);
        write_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            #1 check_val("full_drain", {writedata_left, writedata_right},
                         {DATA_W'(24'h10 + i), DATA_W'(24'h20 + i)});
            tick();
        end

        // Saturation: 17 more underruns on a 4-bit counter
        #1 check_val("sat_pre", underrun_cnt, 3);
        for (int k = 0; k < 17; k++) tick();
        write_ready = 1'b0;
        #1 check_val("sat_cnt", underrun_cnt, 15);

        // Reset mid-stream: RUN with three entries and a held sample
        proc_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            proc_out_left = DATA_W'(24'h30 + i); proc_out_right = '0;
            tick();
        end
        proc_out_valid = 1'b0;
        read_ready = 1'b1; readdata_left = 24'h333; readdata_right = 24'h444;
        tick();
        read_ready = 1'b0;
        #1 check_val("mr_pre", {running, proc_in_valid}, 2'b11);
        #2 reset = 1'b0; write_ready = 1'b1; read_ready = 1'b1;
        #1 check_val("mr_running", running, 0);
        check_val("mr_strobes", {read, write, proc_in_valid}, 0);
        check_val("mr_data", {proc_in_left, writedata_left}, 0);
        check_val("mr_pout_ready", proc_out_ready, 1);
        check_val("mr_cnts", {underrun_cnt, overrun_cnt}, 0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1 check_val("mr_idle_read", read, 0);
        read_ready = 1'b0; write_ready = 1'b0;
        tick(); tick(); tick();
        #1 check_val("mr_fifo_empty", running, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
